// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and
// default timing constants for the 66 MHz system clock.
package btn_pkg;

  typedef logic [1:0] btn_state_t;

  localparam btn_state_t RELEASED   = 2'd0;
  localparam btn_state_t PRESS_DB   = 2'd1;
  localparam btn_state_t PRESSED    = 2'd2;
  localparam btn_state_t RELEASE_DB = 2'd3;

  // 1 ms debounce and 1 s long-press at 66 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 66000;
  localparam int unsigned LONG_CYCLES_DEF     = 66000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; both flops reset to
// RST_VAL so the first synchronized sample after reset is a known level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_ctrl.sv
// Push-button conditioner: debounces a raw pad into a clean level and
// single-cycle press / release / long-press events.
//   state      | meaning
//   RELEASED   | stable released level, waiting for a press
//   PRESS_DB   | pressed seen, counting stable cycles before accepting
//   PRESSED    | press accepted, hold timer running
//   RELEASE_DB | released seen, counting stable cycles; hold timer still runs
module btn_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter logic        ACTIVE_LOW      = 1'b1
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_btn,
  output logic out_level,
  output logic out_press,
  output logic out_release,
  output logic out_long
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("btn_ctrl: LONG_CYCLES must be > DEBOUNCE_CYCLES");
  end

  logic sync_btn;
  logic b;

  btn_state_t        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  sync_2ff #(
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk_i  (in_clk),
    .rst_n_i(in_rst_n),
    .d_i    (in_btn),
    .q_o    (sync_btn)
  );

  assign b = ACTIVE_LOW ? ~sync_btn : sync_btn;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= RELEASED;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      RELEASED: begin
        if (b) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!b) begin
          state_d = RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!b) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (b) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = RELEASED;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = RELEASED;
        db_cnt_d = '0;
      end
    endcase
  end

  // Long-press fires on the edge the hold counter reaches its last value,
  // so it lands LONG_CYCLES-1 cycles after the press pulse.
  always_comb begin
    press_d     = (state_q == PRESS_DB) && (state_d == PRESSED);
    release_d   = (state_q == RELEASE_DB) && (state_d == RELEASED);
    level_d     = (state_d == PRESSED) || (state_d == RELEASE_DB);
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (press_d) begin
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if ((state_q == PRESSED) || (state_q == RELEASE_DB)) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      if ((hold_cnt_d == HOLD_LAST) && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign out_level   = level_q;
  assign out_press   = press_q;
  assign out_release = release_q;
  assign out_long    = long_q;

endmodule
